ama_riscv_host_mailbox: RTL and testbench
=========================================

Name: ama_riscv_host_mailbox

Overview:
- Memory-mapped host interface on the core's MMIO port: the device end of the tohost/console/counter protocol that the simulation host and the bench poll.
- Holds the TOHOST/FROMHOST registers and a console TX FIFO drained by the host over valid/ready.
- Holds 64-bit cycle and retired-instruction counters with a software reset.
- Sits beside the dmem on the core's load/store path; its outputs go to the top level for the bench or external host.

Parameters:
FIFO_DEPTH, 8, console FIFO entries; power of 2, >= 2
CNT_W, 64, counter width; fixed 64 (LO/HI split)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core MMIO request valid
req_ready  out  1  request accepted this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  6  byte offset, word-aligned; bits [1:0] ignored
req_wdata  in  32  write data
rsp_valid  out  1  read data valid, 1 cycle after an accepted read
rsp_data  out  32  read data
inst_retired  in  1  core retired a non-bubble instruction this cycle
tohost  out  32  TOHOST register
tohost_done  out  1  equals tohost[0]
fromhost_we  in  1  host write strobe for FROMHOST
fromhost_wdata  in  32  host write data
con_valid  out  1  console byte available
con_data  out  8  console byte at FIFO head
con_ready  in  1  host pops the byte when con_valid && con_ready
mmio_reset_cnt  out  1  one-cycle pulse after the counters are reset

Behaviour:
- Reset: all registers, counters, snapshot and FIFO pointers are 0. rsp_valid=0, rsp_data=0, con_valid=0, mmio_reset_cnt=0, tohost=0.
- Reset mid-operation discards FIFO contents and any pending response.
- Accept: req_valid && req_ready. req_ready=1 except for a write to CON_TX while the FIFO is full. A refused request is held by the core, unchanged, until accepted.
- Reads: rsp_valid=1 and rsp_data are registered, exactly 1 cycle after acceptance. Back-to-back reads are supported at 1 per cycle.
- Register map:
  - 0x00 TOHOST (RW): sticky. Once tohost[0]=1, further writes are ignored until reset.
  - 0x04 FROMHOST (RW): core write stores wdata. A host fromhost_we write in the same cycle wins.
  - 0x08 CON_TX: write pushes wdata[7:0]. Read returns {16'b0, count[7:0], 6'b0, full, empty}.
  - 0x0C CNT_CTRL: any write zeroes both counters on the next edge; mmio_reset_cnt pulses 1 cycle later. Read returns 0.
  - 0x10 CYCLE_LO: read returns the low word and latches the high word into a snapshot.
  - 0x14 CYCLE_HI: read returns the snapshot.
  - 0x18 INSTR_LO / 0x1C INSTR_HI: same LO/HI snapshot scheme, separate snapshot.
  - Unmapped offsets: reads return 0, writes are ignored.
- Counters:
  - Cycle counter +1 every cycle, instruction counter +1 when inst_retired.
  - Both wrap modulo 2^64.
  - Both freeze while tohost_done=1.
  - A CNT_CTRL write has priority over an increment in the same cycle.
- FIFO:
  - con_valid = !empty, registered. A push into an empty FIFO is visible the next cycle.
  - Full is evaluated before the same-cycle pop, so a full FIFO stalls a push even if a pop occurs that cycle.
  - Push and pop together on a non-full, non-empty FIFO: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count has width log2(FIFO_DEPTH)+1.

Test Plan:
- Reset, then write TOHOST=0x1 -> tohost=0x1, tohost_done=1. Then write 0x6 -> tohost stays 0x1.
- Push bytes 0x41..0x48 with con_ready=0 -> 8 accepted. Ninth push sees req_ready=0 until con_ready=1 pops 0x41. Drain order is 0x41..0x49.
- Let 100 cycles elapse with inst_retired high every other cycle, then read CYCLE_LO/HI and INSTR_LO/HI -> values consistent with 100/50 since the last reset; HI=0.
- Force the cycle counter to 0x0000_0000_FFFF_FFFF, read CYCLE_LO, let it wrap, read CYCLE_HI -> HI=0 (snapshot), not 1.
- Write CNT_CTRL in a cycle with inst_retired=1 -> both counters 0 next cycle; mmio_reset_cnt high for exactly 1 cycle.
- Host fromhost_we=1 with 0xAA in the same cycle as a core write of 0x55 to FROMHOST -> FROMHOST reads 0xAA. Assert rst_n low mid-FIFO-drain -> con_valid=0 immediately.

Source files
------------

// File: rtl/ama_riscv_host_mailbox.sv
// Host mailbox: TOHOST/FROMHOST, console TX FIFO and 64-bit cycle/instret counters on the MMIO port.
// Latency: reads respond 1 cycle after acceptance; writes take effect on the accepting edge.
// Backpressure: req_ready drops only for a CON_TX write while the console FIFO is full.
module ama_riscv_host_mailbox #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [5:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic        inst_retired,
    output logic [31:0] tohost,
    output logic        tohost_done,
    input  logic        fromhost_we,
    input  logic [31:0] fromhost_wdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        mmio_reset_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [3:0] A_TOHOST   = 4'h0;
    localparam logic [3:0] A_FROMHOST = 4'h1;
    localparam logic [3:0] A_CON_TX   = 4'h2;
    localparam logic [3:0] A_CNT_CTRL = 4'h3;
    localparam logic [3:0] A_CYC_LO   = 4'h4;
    localparam logic [3:0] A_CYC_HI   = 4'h5;
    localparam logic [3:0] A_INS_LO   = 4'h6;
    localparam logic [3:0] A_INS_HI   = 4'h7;

    logic [31:0]        r_tohost;
    logic [31:0]        r_fromhost;
    logic [CNT_W-1:0]   r_cyc_cnt;
    logic [CNT_W-1:0]   r_ins_cnt;
    logic [CNT_W-33:0]  r_cyc_snap;
    logic [CNT_W-33:0]  r_ins_snap;
    logic               r_reset_cnt;
    logic               r_rsp_vld;
    logic [31:0]        r_rsp_dat;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic [3:0]         w_word;
    logic               w_full;
    logic               w_empty;
    logic               w_acc;
    logic               w_wr;
    logic               w_rd;
    logic               w_push;
    logic               w_pop;
    logic               w_clr;
    logic               w_run;
    logic [31:0]        w_rdata;

    assign w_word    = req_addr[5:2];
    assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    // Full is judged on current state, so a same-cycle pop never frees room for a push.
    assign req_ready = !(req_we && (w_word == A_CON_TX) && w_full);
    assign w_acc     = req_valid && req_ready;
    assign w_wr      = w_acc && req_we;
    assign w_rd      = w_acc && !req_we;
    assign w_push    = w_wr && (w_word == A_CON_TX);
    assign w_pop     = !w_empty && con_ready;
    assign w_clr     = w_wr && (w_word == A_CNT_CTRL);
    assign w_run     = !r_tohost[0];

    always_comb begin
        w_rdata = '0;
        case (w_word)
            A_TOHOST:   w_rdata = r_tohost;
            A_FROMHOST: w_rdata = r_fromhost;
            A_CON_TX:   w_rdata = {16'b0, 8'(r_count), 6'b0, w_full, w_empty};
            A_CYC_LO:   w_rdata = r_cyc_cnt[31:0];
            A_CYC_HI:   w_rdata = r_cyc_snap;
            A_INS_LO:   w_rdata = r_ins_cnt[31:0];
            A_INS_HI:   w_rdata = r_ins_snap;
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tohost    <= '0;
            r_fromhost  <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_dat   <= '0;
            r_cyc_snap  <= '0;
            r_ins_snap  <= '0;
        end else begin
            if (w_wr && (w_word == A_TOHOST) && !r_tohost[0])
                r_tohost <= req_wdata;
            if (fromhost_we)
                r_fromhost <= fromhost_wdata;
            else if (w_wr && (w_word == A_FROMHOST))
                r_fromhost <= req_wdata;
            r_rsp_vld <= w_rd;
            r_rsp_dat <= w_rd ? w_rdata : '0;
            // LO read captures HI so a later HI read is coherent with it.
            if (w_rd && (w_word == A_CYC_LO))
                r_cyc_snap <= r_cyc_cnt[CNT_W-1:32];
            if (w_rd && (w_word == A_INS_LO))
                r_ins_snap <= r_ins_cnt[CNT_W-1:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt   <= '0;
            r_ins_cnt   <= '0;
            r_reset_cnt <= 1'b0;
        end else begin
            r_reset_cnt <= w_clr;
            if (w_clr) begin
                r_cyc_cnt <= '0;
                r_ins_cnt <= '0;
            end else if (w_run) begin
                r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
                if (inst_retired)
                    r_ins_cnt <= r_ins_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= req_wdata[7:0];
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rsp_valid      = r_rsp_vld;
    assign rsp_data       = r_rsp_dat;
    assign tohost         = r_tohost;
    assign tohost_done    = r_tohost[0];
    assign con_valid      = !w_empty;
    assign con_data       = r_mem[r_rd_ptr];
    assign mmio_reset_cnt = r_reset_cnt;

endmodule

// File: tb/tb_ama_riscv_host_mailbox.sv
// Bench for ama_riscv_host_mailbox: directed table, hand-written corner sequences and
// randomized traffic compared each cycle against a queue/longint reference model.
module tb_ama_riscv_host_mailbox;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_retired = 1'b0;
    logic [31:0] tohost;
    logic        tohost_done;
    logic        fromhost_we = 1'b0;
    logic [31:0] fromhost_wdata = '0;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;
    logic        mmio_reset_cnt;

    ama_riscv_host_mailbox #(.FIFO_DEPTH(DEPTH), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inst_retired(inst_retired),
        .tohost(tohost), .tohost_done(tohost_done),
        .fromhost_we(fromhost_we), .fromhost_wdata(fromhost_wdata),
        .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
        .mmio_reset_cnt(mmio_reset_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint unsigned m_cyc, m_ins;
    logic [31:0] m_cyc_snap, m_ins_snap, m_tohost, m_fromhost, m_rsp_d;
    logic        m_rsp_v, m_pulse, m_acc;
    logic [7:0]  q[$];
    logic [7:0]  popped[$];

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] w);
        logic full, empty;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        case (w)
            4'h0: return m_tohost;
            4'h1: return m_fromhost;
            4'h2: return {16'b0, 8'(q.size()), 6'b0, full, empty};
            4'h4: return m_cyc[31:0];
            4'h5: return m_cyc_snap;
            4'h6: return m_ins[31:0];
            4'h7: return m_ins_snap;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_reset();
        m_cyc = 0; m_ins = 0; m_cyc_snap = 0; m_ins_snap = 0;
        m_tohost = 0; m_fromhost = 0; m_rsp_d = 0;
        m_rsp_v = 0; m_pulse = 0; m_acc = 0;
        q.delete();
    endfunction

    // One clock: check req_ready, advance the model across the edge, compare outputs.
    task automatic tick();
        logic [3:0]  w;
        logic        rdy, wr, rd;
        logic [31:0] rv;
        #1;
        w   = req_addr[5:2];
        rdy = !(req_we && w == 4'h2 && q.size() == DEPTH);
        chk("req_ready", 64'(req_ready), 64'(rdy));
        m_acc = req_valid && rdy;
        wr = m_acc && req_we;
        rd = m_acc && !req_we;
        rv = model_read(w);
        if (con_valid && con_ready) popped.push_back(con_data);
        @(posedge clk);
        m_rsp_v = rd;
        m_rsp_d = rd ? rv : 32'h0;
        if (rd && w == 4'h4) m_cyc_snap = m_cyc[63:32];
        if (rd && w == 4'h6) m_ins_snap = m_ins[63:32];
        m_pulse = wr && w == 4'h3;
        if (m_pulse) begin
            m_cyc = 0; m_ins = 0;
        end else if (!m_tohost[0]) begin
            m_cyc = m_cyc + 1;
            if (inst_retired) m_ins = m_ins + 1;
        end
        if (wr && w == 4'h0 && !m_tohost[0]) m_tohost = req_wdata;
        if (fromhost_we) m_fromhost = fromhost_wdata;
        else if (wr && w == 4'h1) m_fromhost = req_wdata;
        if (q.size() != 0 && con_ready) void'(q.pop_front());
        if (wr && w == 4'h2) q.push_back(req_wdata[7:0]);
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
        if (m_rsp_v) chk("rsp_data", 64'(rsp_data), 64'(m_rsp_d));
        chk("tohost", 64'(tohost), 64'(m_tohost));
        chk("tohost_done", 64'(tohost_done), 64'(m_tohost[0]));
        chk("con_valid", 64'(con_valid), 64'(q.size() != 0));
        if (q.size() != 0) chk("con_data", 64'(con_data), 64'(q[0]));
        chk("mmio_reset_cnt", 64'(mmio_reset_cnt), 64'(m_pulse));
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        inst_retired = 0; fromhost_we = 0; fromhost_wdata = 0; con_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset con_valid", 64'(con_valid), 64'h0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset rsp_data", 64'(rsp_data), 64'h0);
        chk("reset tohost", 64'(tohost), 64'h0);
        chk("reset mmio_reset_cnt", 64'(mmio_reset_cnt), 64'h0);
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic mmio(input logic we, input logic [5:0] a, input logic [31:0] d);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
        tick();
        req_valid = 0; req_we = 0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 6'h04, 32'h55,   32'h0};
        tbl[1]  = '{1'b0, 6'h04, 32'h0,    32'h55};
        tbl[2]  = '{1'b0, 6'h0C, 32'h0,    32'h0};
        tbl[3]  = '{1'b1, 6'h24, 32'hDEAD, 32'h0};
        tbl[4]  = '{1'b0, 6'h24, 32'h0,    32'h0};
        tbl[5]  = '{1'b0, 6'h08, 32'h0,    32'h1};
        tbl[6]  = '{1'b1, 6'h08, 32'h41,   32'h0};
        tbl[7]  = '{1'b0, 6'h08, 32'h0,    32'h100};
        tbl[8]  = '{1'b1, 6'h00, 32'h6,    32'h0};
        tbl[9]  = '{1'b0, 6'h00, 32'h0,    32'h6};
        tbl[10] = '{1'b1, 6'h00, 32'h1,    32'h0};
        tbl[11] = '{1'b0, 6'h00, 32'h0,    32'h1};
        tbl[12] = '{1'b1, 6'h00, 32'h6,    32'h0};
        tbl[13] = '{1'b0, 6'h03, 32'h0,    32'h1};

        model_reset();
        do_reset();

        // Directed register table
        for (int i = 0; i < 14; i++) begin
            mmio(tbl[i].we, tbl[i].addr, tbl[i].wdata);
            if (!tbl[i].we) chk($sformatf("tbl[%0d] rdata", i), 64'(rsp_data), 64'(tbl[i].exp));
        end
        chk("tohost sticky", 64'(tohost), 64'h1);
        chk("tohost_done set", 64'(tohost_done), 64'h1);

        // FIFO fill, stalled ninth push, ordered drain
        do_reset();
        popped.delete();
        for (int i = 0; i < 8; i++) mmio(1, 6'h08, 32'h41 + i);
        req_valid = 1; req_we = 1; req_addr = 6'h08; req_wdata = 32'h49;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full stall ready", 64'(req_ready), 64'h0);
        end
        con_ready = 1;
        tick();
        begin
            int budget = 10;
            while (!m_acc && budget > 0) begin tick(); budget--; end
            chk("ninth push accepted", 64'(m_acc), 64'h1);
        end
        req_valid = 0; req_we = 0;
        for (int i = 0; i < 20 && con_valid; i++) tick();
        chk("drain count", 64'(popped.size()), 64'd9);
        for (int i = 0; i < popped.size() && i < 9; i++)
            chk($sformatf("drain[%0d]", i), 64'(popped[i]), 64'(8'h41 + i));
        con_ready = 0;

        // Counter accumulation and LO/HI snapshot
        do_reset();
        for (int i = 0; i < 100; i++) begin
            inst_retired = (i % 2 == 0);
            tick();
        end
        inst_retired = 0;
        mmio(0, 6'h10, 0); chk("cycle_lo 100", 64'(rsp_data), 64'd100);
        mmio(0, 6'h14, 0); chk("cycle_hi 0", 64'(rsp_data), 64'd0);
        mmio(0, 6'h18, 0); chk("instr_lo 50", 64'(rsp_data), 64'd50);
        mmio(0, 6'h1C, 0); chk("instr_hi 0", 64'(rsp_data), 64'd0);

        // Wrap of the low word between LO and HI reads
        force dut.r_cyc_cnt = 64'h0000_0000_FFFF_FFFD;
        #1;
        release dut.r_cyc_cnt;
        m_cyc = 64'h0000_0000_FFFF_FFFD;
        mmio(0, 6'h10, 0); chk("wrap cycle_lo", 64'(rsp_data), 64'hFFFF_FFFD);
        repeat (4) tick();
        mmio(0, 6'h14, 0); chk("wrap cycle_hi snapshot", 64'(rsp_data), 64'h0);
        mmio(0, 6'h10, 0); chk("post-wrap cycle_lo", 64'(rsp_data), 64'h3);
        mmio(0, 6'h14, 0); chk("post-wrap cycle_hi", 64'(rsp_data), 64'h1);

        // Counter clear against a retiring instruction
        inst_retired = 1;
        mmio(1, 6'h0C, 32'h0);
        chk("clear pulse high", 64'(mmio_reset_cnt), 64'h1);
        inst_retired = 0;
        tick();
        chk("clear pulse low", 64'(mmio_reset_cnt), 64'h0);
        mmio(0, 6'h10, 0); chk("cleared cycle_lo", 64'(rsp_data), 64'h1);
        mmio(0, 6'h18, 0); chk("cleared instr_lo", 64'(rsp_data), 64'h0);

        // Host write beats core write to FROMHOST
        fromhost_we = 1; fromhost_wdata = 32'hAA;
        mmio(1, 6'h04, 32'h55);
        fromhost_we = 0;
        mmio(0, 6'h04, 0); chk("fromhost host wins", 64'(rsp_data), 64'hAA);

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) mmio(1, 6'h08, 32'h60 + i);
        con_ready = 1;
        tick();
        do_reset();

        // Randomized traffic against the model; refused requests are held
        for (int n = 0; n < 3000; n++) begin
            if (!(req_valid && !m_acc)) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_we    = $urandom_range(0, 1);
                req_addr  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                        : 6'($urandom_range(0, 7) << 2);
                req_wdata = $urandom;
                if (req_addr[5:2] == 4'h0 && $urandom_range(0, 15) != 0) req_wdata[0] = 1'b0;
                if (req_addr[5:2] == 4'h2 && req_we) req_valid = 1'b1;
            end
            inst_retired   = $urandom_range(0, 1);
            fromhost_we    = ($urandom_range(0, 7) == 0);
            fromhost_wdata = $urandom;
            con_ready      = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
